live_sim_sequencer: RTL
=======================

LIVE_SIM_SEQUENCER -- requirements
Module: live_sim_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the period, on-time and delay counters.
REQ-002 SHALL have parameter NSP_W, default 16, width of the spill count.
REQ-003 SHALL have port clk  input  1  system clock; the block SHALL use this single clock only.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port cfg_period  input  CNT_W  spill period in clk cycles.
REQ-006 SHALL have port cfg_on  input  CNT_W  live-high cycles per period.
REQ-007 SHALL have port cfg_delay  input  CNT_W  cycles from start to the first live cycle.
REQ-008 SHALL have port cfg_nspill  input  NSP_W  spills to run; 0 means run until stopped.
REQ-009 SHALL have port start  input  1  one-cycle start command.
REQ-010 SHALL have port stop  input  1  one-cycle abort command.
REQ-011 SHALL have port out_live  output  1  live gate to the detector trigger logic.
REQ-012 SHALL have port out_spill_start  output  1  pulse on the first live cycle of each spill.
REQ-013 SHALL have port out_spill_end  output  1  pulse on the last cycle of each period.
REQ-014 SHALL have port busy  output  1  high in the DELAY, ON and OFF states.
REQ-015 SHALL have port done  output  1  high in the DONE state.
REQ-016 SHALL have port cfg_err  output  1  sticky flag set when a start is rejected.
REQ-017 SHALL have port spill_cnt  output  NSP_W  completed spills since the last accepted start.

Function
REQ-018 SHALL implement the states IDLE, DELAY, ON, OFF and DONE, with every output registered.
REQ-019 SHALL act on start only in IDLE or DONE; a start in DELAY, ON or OFF SHALL be ignored.
REQ-020 SHALL reject a start when cfg_period==0, cfg_on==0 or cfg_on>cfg_period: set cfg_err, stay in or go to IDLE.
REQ-021 SHALL, on an accepted start, latch all cfg_* values, clear cfg_err and spill_cnt, and enter DELAY.
REQ-022 SHALL ignore changes to cfg_* while busy.
REQ-023 SHALL, for a start accepted on cycle t, drive out_live high first on cycle t+1+cfg_delay; cfg_delay==0 gives a rise at t+1.
REQ-024 SHALL hold out_live high for exactly cfg_on cycles (ON), then low for cfg_period-cfg_on cycles (OFF).
REQ-025 SHALL skip OFF when cfg_on==cfg_period, so out_live stays high across spill boundaries.
REQ-026 SHALL assert out_spill_start on the first ON cycle of each spill.
REQ-027 SHALL assert out_spill_end on the final cycle of each period, whether that cycle is in ON or OFF.
REQ-028 SHALL increment spill_cnt in the cycle after out_spill_end and saturate it at all-ones.
REQ-029 SHALL, at period end, enter DONE if cfg_nspill!=0 and the new count equals cfg_nspill; otherwise it SHALL re-enter ON with no gap cycle.
REQ-030 SHALL hold out_live low in DONE and keep done high until the next accepted start.
REQ-031 SHALL, on stop in DELAY, ON or OFF, enter IDLE on the next cycle, drive out_live low from that cycle and not assert out_spill_end.
REQ-032 SHALL let stop win when start and stop arrive in the same cycle: no start is accepted.
REQ-033 SHALL have a stop in IDLE or DONE clear done and return to IDLE.
REQ-034 SHALL use counter compares at full CNT_W width with no wrap-around; the OFF length SHALL be computed once at start.

Reset
REQ-035 SHALL, while rst_n is low, force the state to IDLE and clear all counters.
REQ-036 SHALL, while rst_n is low, clear out_live, out_spill_start, out_spill_end, busy, done, cfg_err and spill_cnt to 0.
REQ-037 SHALL, when reset asserts mid-spill, drop out_live immediately (asynchronously).
REQ-038 SHALL require a new start after reset release before any output activity.

Structure
REQ-039 SHALL place the state encoding and the CNT_W/NSP_W defaults in the shared package live_sim_pkg.
REQ-040 SHALL instantiate exactly one sub-module, live_sim_timer: a loadable down-counter with a zero flag, used for the DELAY, ON and OFF intervals.

Verification
REQ-041 SHALL cover: period=10, on=6, delay=3, nspill=2, start at t0 -> out_live high t0+4..t0+9 and t0+14..t0+19; spill_end at t0+13 and t0+23; done at t0+24; spill_cnt=2.
REQ-042 SHALL cover: on=period=5, nspill=3, delay=0 -> out_live high for 15 contiguous cycles; three spill_start pulses, 5 cycles apart.
REQ-043 SHALL cover: on=0, or on=11 with period=10 -> cfg_err=1, busy stays 0, out_live stays 0.
REQ-044 SHALL cover: nspill=0, stop applied on the 3rd ON cycle of spill 4 -> out_live low next cycle, state IDLE, spill_cnt=3, no spill_end.
REQ-045 SHALL cover: start and stop asserted together in IDLE -> no activity; a start while busy -> timing unchanged.
REQ-046 SHALL cover: rst_n driven low mid-ON -> all outputs 0 asynchronously; after release, outputs stay idle until the next start.

Source files
------------

// File: rtl/live_sim_pkg.sv
// Shared types and defaults for the live-spill sequencer: state encoding,
// counter width defaults and a small state classification helper.
package live_sim_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int NSP_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_ON    = 3'd2,
        ST_OFF   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic is_busy(state_e s);
        return (s == ST_DELAY) || (s == ST_ON) || (s == ST_OFF);
    endfunction

endpackage

// File: rtl/live_sim_timer.sv
// Loadable down-counter with a zero flag; the count is the number of cycles
// still to run in the current interval after the present one.
module live_sim_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/live_sim_sequencer.sv
// Spill sequencer: after a start and an initial delay, produces a periodic
// live gate with spill start/end pulses for a programmed number of spills.
module live_sim_sequencer
    import live_sim_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NSP_W = NSP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_on,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [NSP_W-1:0] cfg_nspill,
    input  logic             start,
    input  logic             stop,
    output logic             out_live,
    output logic             out_spill_start,
    output logic             out_spill_end,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [NSP_W-1:0] spill_cnt,
    output logic [2:0]       state_dbg
);

    state_e           state, nxt;
    logic [CNT_W-1:0] on_r, off_r, off_eff, ld_val, tmr_cnt;
    logic [NSP_W-1:0] nsp_r, cnt_inc;
    logic             ld, tmr_en, tmr_zero, accept, reject, period_end;
    logic             ss_nxt, se_nxt, next_last, cfg_ok;

    assign cfg_ok  = (cfg_period != '0) && (cfg_on != '0) && (cfg_on <= cfg_period);
    assign cnt_inc = (spill_cnt == '1) ? spill_cnt : spill_cnt + NSP_W'(1);
    assign tmr_en  = is_busy(state);

    live_sim_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ld),
        .en       (tmr_en),
        .load_val (ld_val),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    always_comb begin
        nxt        = state;
        ld         = 1'b0;
        ld_val     = '0;
        accept     = 1'b0;
        reject     = 1'b0;
        period_end = 1'b0;
        ss_nxt     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (stop) begin
                    nxt = ST_IDLE;
                end else if (start) begin
                    if (!cfg_ok) begin
                        reject = 1'b1;
                        nxt    = ST_IDLE;
                    end else begin
                        accept = 1'b1;
                        ld     = 1'b1;
                        if (cfg_delay == '0) begin
                            nxt    = ST_ON;
                            ld_val = cfg_on - CNT_W'(1);
                            ss_nxt = 1'b1;
                        end else begin
                            nxt    = ST_DELAY;
                            ld_val = cfg_delay - CNT_W'(1);
                        end
                    end
                end
            end
            ST_DELAY: begin
                if (stop) begin
                    nxt = ST_IDLE;
                end else if (tmr_zero) begin
                    nxt    = ST_ON;
                    ld     = 1'b1;
                    ld_val = on_r - CNT_W'(1);
                    ss_nxt = 1'b1;
                end
            end
            ST_ON: begin
                if (stop) begin
                    nxt = ST_IDLE;
                end else if (tmr_zero) begin
                    if (off_r != '0) begin
                        nxt    = ST_OFF;
                        ld     = 1'b1;
                        ld_val = off_r - CNT_W'(1);
                    end else begin
                        period_end = 1'b1;
                    end
                end
            end
            ST_OFF: begin
                if (stop) begin
                    nxt = ST_IDLE;
                end else if (tmr_zero) begin
                    period_end = 1'b1;
                end
            end
            default: nxt = ST_IDLE;
        endcase
        // A finished period either completes the run or starts the next spill at once.
        if (period_end) begin
            if ((nsp_r != '0) && (cnt_inc == nsp_r)) begin
                nxt = ST_DONE;
            end else begin
                nxt    = ST_ON;
                ld     = 1'b1;
                ld_val = on_r - CNT_W'(1);
                ss_nxt = 1'b1;
            end
        end
    end

    // Outputs are registered, so the "last cycle of period" must be known one cycle early.
    assign off_eff   = accept ? (cfg_period - cfg_on) : off_r;
    assign next_last = ld ? (ld_val == '0) : (tmr_cnt == CNT_W'(1));
    assign se_nxt    = next_last &&
                       ((nxt == ST_OFF) || ((nxt == ST_ON) && (off_eff == '0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            on_r            <= '0;
            off_r           <= '0;
            nsp_r           <= '0;
            out_live        <= 1'b0;
            out_spill_start <= 1'b0;
            out_spill_end   <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            cfg_err         <= 1'b0;
            spill_cnt       <= '0;
        end else begin
            state           <= nxt;
            out_live        <= (nxt == ST_ON);
            out_spill_start <= ss_nxt;
            out_spill_end   <= se_nxt;
            busy            <= is_busy(nxt);
            done            <= (nxt == ST_DONE);
            if (accept) begin
                on_r      <= cfg_on;
                off_r     <= cfg_period - cfg_on;
                nsp_r     <= cfg_nspill;
                cfg_err   <= 1'b0;
                spill_cnt <= '0;
            end else if (reject) begin
                cfg_err <= 1'b1;
            end
            if (period_end) begin
                spill_cnt <= cnt_inc;
            end
        end
    end

    assign state_dbg = state;

endmodule
